// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the hardwired control sequencer.
// Opcode values, the 4-bit state encoding, ALU operation constants and
// the packed control vector. The optional mul/div sequences are enabled
// with the CTRL_MULDIV_EN macro; without it those opcodes are illegal.
package ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_W       = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // The ALU is driven with opcode values; address calculation uses add.
    localparam logic [OP_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [OP_W-1:0] ALU_ADD  = OP_ADD;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    // Instruction classes that share an execute sequence.
    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_MULDIV,
        CL_LD,
        CL_LDI,
        CL_SHORT,    // in, out, mflo, mfhi, nop: single execute step
        CL_HALT,
        CL_ILLEGAL
    } iclass_e;

    typedef struct packed {
        logic            pc_out;
        logic            zhi_out;
        logic            zlo_out;
        logic            mdr_out;
        logic            hi_out;
        logic            lo_out;
        logic            inport_out;
        logic            c_out;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            rin;
        logic            rout;
        logic            ba_out;
        logic            mar_in;
        logic            mdr_in;
        logic            pc_in;
        logic            ir_in;
        logic            y_in;
        logic            z_in;
        logic            hi_in;
        logic            lo_in;
        logic            outport_in;
        logic            inc_pc;
        logic            read;
        logic            write;
        logic [OP_W-1:0] alu_op;
        logic            run;
        logic            illegal;
    } ctrl_t;

    function automatic iclass_e classify(input logic [OP_W-1:0] op);
        iclass_e cls;
        case (op)
            OP_LD:                                  cls = CL_LD;
            OP_LDI:                                 cls = CL_LDI;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        cls = CL_RTYPE;
`ifdef CTRL_MULDIV_EN
            OP_DIV, OP_MUL:                         cls = CL_MULDIV;
`endif
            OP_IN, OP_OUT, OP_MFLO, OP_MFHI, OP_NOP: cls = CL_SHORT;
            OP_HALT:                                cls = CL_HALT;
            default:                                cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from (state, opcode) to the control
// vector. Moore-style: nothing here depends on handshake inputs.
// Mul/div steps exist only when CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opcode_i,
    output ctrl_t           ctrl_o
);

    iclass_e cls;
    assign cls = classify(opcode_i);

    // Per-state control decode; every unlisted control stays 0.
    always_comb begin
        ctrl_o = '0;
        ctrl_o.run = (state_i != S_IDLE) && (state_i != S_HALT);
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1;
                ctrl_o.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_o.zlo_out = 1'b1;
                ctrl_o.pc_in   = 1'b1;
                ctrl_o.read    = 1'b1;
                ctrl_o.mdr_in  = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CL_RTYPE, CL_MULDIV: begin
                        ctrl_o.grb  = 1'b1;
                        ctrl_o.rout = 1'b1;
                        ctrl_o.y_in = 1'b1;
                    end
                    CL_LD, CL_LDI: begin
                        ctrl_o.grb    = 1'b1;
                        ctrl_o.ba_out = 1'b1;
                        ctrl_o.y_in   = 1'b1;
                    end
                    CL_SHORT: begin
                        case (opcode_i)
                            OP_IN: begin
                                ctrl_o.inport_out = 1'b1;
                                ctrl_o.gra        = 1'b1;
                                ctrl_o.rin        = 1'b1;
                            end
                            OP_OUT: begin
                                ctrl_o.gra        = 1'b1;
                                ctrl_o.rout       = 1'b1;
                                ctrl_o.outport_in = 1'b1;
                            end
                            OP_MFLO: begin
                                ctrl_o.lo_out = 1'b1;
                                ctrl_o.gra    = 1'b1;
                                ctrl_o.rin    = 1'b1;
                            end
                            OP_MFHI: begin
                                ctrl_o.hi_out = 1'b1;
                                ctrl_o.gra    = 1'b1;
                                ctrl_o.rin    = 1'b1;
                            end
                            default: ;   // nop: no controls
                        endcase
                    end
                    CL_ILLEGAL: ctrl_o.illegal = 1'b1;
                    default: ;           // halt: leaves through next-state only
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_RTYPE, CL_MULDIV: begin
                        ctrl_o.grc    = 1'b1;
                        ctrl_o.rout   = 1'b1;
                        ctrl_o.alu_op = opcode_i;
                        ctrl_o.z_in   = 1'b1;
                    end
                    CL_LD, CL_LDI: begin
                        ctrl_o.c_out  = 1'b1;
                        ctrl_o.alu_op = ALU_ADD;
                        ctrl_o.z_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_RTYPE, CL_LDI: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.gra     = 1'b1;
                        ctrl_o.rin     = 1'b1;
                    end
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.lo_in   = 1'b1;
                    end
`endif
                    CL_LD: begin
                        ctrl_o.zlo_out = 1'b1;
                        ctrl_o.mar_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV: begin
                        ctrl_o.zhi_out = 1'b1;
                        ctrl_o.hi_in   = 1'b1;
                    end
`endif
                    CL_LD: begin
                        ctrl_o.read   = 1'b1;
                        ctrl_o.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                if (cls == CL_LD) begin
                    ctrl_o.mdr_out = 1'b1;
                    ctrl_o.gra     = 1'b1;
                    ctrl_o.rin     = 1'b1;
                end
            end
            default: ;                   // IDLE, HALT: all controls 0
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping each instruction
// through fetch (T0-T2) and execute (T3-T7). Holds the state register and
// next-state logic; control decode lives in ctrl_decode. Define
// CTRL_MULDIV_EN to enable the mul/div sequences.
// Memory handshake: a read in T1 or ld-T6 completes on the rising edge
// where Mem_ready is sampled high; until then state and outputs hold.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  Mem_ready,
    output logic PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout,
    output logic Gra, Grb, Grc, Rin, Rout, BAout,
    output logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, OutPort_in,
    output logic IncPC, Read, Write,
    output logic [OP_W-1:0]       alu_op,
    output logic                  Run,
    output logic                  Illegal,
    output logic [3:0]            dbg_state_o
);

    state_e          state_q, state_d;
    logic [OP_W-1:0] opcode;
    iclass_e         cls;
    ctrl_t           ctrl;

    assign opcode = IR[DATA_WIDTH-1:DATA_WIDTH-OP_W];
    assign cls    = classify(opcode);

    // Register operand fields are consumed by the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[DATA_WIDTH-OP_W-1:0];

    // State register; reset returns to IDLE immediately, mid-instruction or not.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: sequence length chosen by instruction class, memory waits in T1/T6.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (Mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (cls)
                    CL_HALT:             state_d = S_HALT;
                    CL_SHORT, CL_ILLEGAL: state_d = S_T0;
                    default:             state_d = S_T4;
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (cls == CL_MULDIV || cls == CL_LD) state_d = S_T6;
                else                                  state_d = S_T0;
            end
            S_T6: begin
                if (cls == CL_LD) begin
                    if (Mem_ready) state_d = S_T7;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    // Output mapping from the decoded control vector.
    always_comb begin
        PCout       = ctrl.pc_out;
        Zhi_out     = ctrl.zhi_out;
        Zlo_out     = ctrl.zlo_out;
        MDRout      = ctrl.mdr_out;
        HIout       = ctrl.hi_out;
        LOout       = ctrl.lo_out;
        Inport_out  = ctrl.inport_out;
        Cout        = ctrl.c_out;
        Gra         = ctrl.gra;
        Grb         = ctrl.grb;
        Grc         = ctrl.grc;
        Rin         = ctrl.rin;
        Rout        = ctrl.rout;
        BAout       = ctrl.ba_out;
        MARin       = ctrl.mar_in;
        MDRin       = ctrl.mdr_in;
        PCin        = ctrl.pc_in;
        IRin        = ctrl.ir_in;
        Yin         = ctrl.y_in;
        Zin         = ctrl.z_in;
        HIin        = ctrl.hi_in;
        LOin        = ctrl.lo_in;
        OutPort_in  = ctrl.outport_in;
        IncPC       = ctrl.inc_pc;
        Read        = ctrl.read;
        Write       = ctrl.write;
        alu_op      = ctrl.alu_op;
        Run         = ctrl.run;
        Illegal     = ctrl.illegal;
        dbg_state_o = state_q;
    end

endmodule
